// File: rtl/decoder_pkg.sv
// Shared types and sizes for the registered 3-to-8 decoder.
//   SEL_W        : width of the select code
//   OUT_W        : width of the one-hot result (1 << SEL_W)
//   dec_code_t   : select code type
//   dec_onehot_t : decoded one-hot vector type
package decoder_pkg;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 1 << SEL_W;

  typedef logic [SEL_W-1:0] dec_code_t;
  typedef logic [OUT_W-1:0] dec_onehot_t;
endpackage

// File: rtl/onehot_dec.sv
// Combinational code -> one-hot decoder.
//   code   : select code
//   en     : decode enable; when low no bit is selected
//   onehot : active-high one-hot result (all zero when disabled)
module onehot_dec
  import decoder_pkg::*;
(
  input  dec_code_t   code,
  input  logic        en,
  output dec_onehot_t onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[code] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with optional output polarity inversion.
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   en         : decode enable
//   in1/in2/in3: code bits, in1 is the MSB
//   out        : registered one-hot (one-cold when OUT_ACTIVE_LOW=1) result
//   out_valid  : registered copy of en
//   out_change : (only with DECODER_CHANGE_DET_EN) one-cycle pulse when the
//                newly registered out differs from its previous value
module decoder_3to8
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             in1,
  input  logic             in2,
  input  logic             in3,
  output logic [OUT_W-1:0] out,
`ifdef DECODER_CHANGE_DET_EN
  output logic             out_change,
`endif
  output logic             out_valid
);

  // Idle/reset pattern; XOR with it applies the output polarity.
  localparam dec_onehot_t OUT_IDLE = {OUT_W{OUT_ACTIVE_LOW}};

  dec_code_t   code;
  dec_onehot_t onehot;
  dec_onehot_t out_d, out_q;
  logic        valid_d, valid_q;

  assign code = {in1, in2, in3};

  onehot_dec u_onehot_dec (
    .code   (code),
    .en     (en),
    .onehot (onehot)
  );

  always_comb begin
    out_d   = onehot ^ OUT_IDLE;
    valid_d = en;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_q   <= OUT_IDLE;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

`ifdef DECODER_CHANGE_DET_EN
  logic change_d, change_q;

  always_comb begin
    change_d = (out_d != out_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      change_q <= 1'b0;
    end else begin
      change_q <= change_d;
    end
  end

  assign out_change = change_q;
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: an active-high and an active-low
// instance share stimulus and are compared against a reference model.
module tb_decoder_3to8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       en = 1'b0;
  logic       in1 = 1'b0, in2 = 1'b0, in3 = 1'b0;
  logic [7:0] out, out_lo;
  logic       out_valid, out_valid_lo;
  logic       out_change, out_change_lo;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [7:0]  prev_exp = 8'h00;

  always #5 sys_clk = ~sys_clk;

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) u_dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .en         (en),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .out        (out),
`ifdef DECODER_CHANGE_DET_EN
    .out_change (out_change),
`endif
    .out_valid  (out_valid)
  );

  decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .en         (en),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .out        (out_lo),
`ifdef DECODER_CHANGE_DET_EN
    .out_change (out_change_lo),
`endif
    .out_valid  (out_valid_lo)
  );

`ifndef DECODER_CHANGE_DET_EN
  assign out_change    = 1'b0;
  assign out_change_lo = 1'b0;
`endif

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Outputs of both instances while reset is asserted.
  task automatic check_reset(input string tag);
    check8({tag, "_out"}, out, 8'h00);
    check8({tag, "_out_lo"}, out_lo, 8'hFF);
    check1({tag, "_valid"}, out_valid, 1'b0);
    check1({tag, "_valid_lo"}, out_valid_lo, 1'b0);
`ifdef DECODER_CHANGE_DET_EN
    check1({tag, "_chg"}, out_change, 1'b0);
    check1({tag, "_chg_lo"}, out_change_lo, 1'b0);
`endif
  endtask

  // Drive one code (inputs applied at the falling edge), let one rising edge
  // capture it, then compare at the following falling edge.
  task automatic step(input logic e, input logic [2:0] c, input string tag);
    logic [7:0] exp;
    en = e;
    {in1, in2, in3} = c;
    @(posedge sys_clk);
    @(negedge sys_clk);
    exp = e ? (8'd1 << c) : 8'h00;
    check8({tag, "_out"}, out, exp);
    check8({tag, "_out_lo"}, out_lo, ~exp);
    check1({tag, "_valid"}, out_valid, e);
    check1({tag, "_valid_lo"}, out_valid_lo, e);
    check1({tag, "_onehot"}, $onehot(out), e);
    check1({tag, "_onecold"}, $onehot(~out_lo), e);
`ifdef DECODER_CHANGE_DET_EN
    check1({tag, "_chg"}, out_change, exp != prev_exp);
    check1({tag, "_chg_lo"}, out_change_lo, exp != prev_exp);
`endif
    prev_exp = exp;
  endtask

  initial begin
    // Reset held while inputs request code 101.
    #1 sys_rst_n = 1'b0;
    en = 1'b1;
    {in1, in2, in3} = 3'b101;
    #1 check_reset("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check_reset("rst_hold");
    end
    sys_rst_n = 1'b1;
    prev_exp  = 8'h00;
    step(1'b1, 3'b101, "rst_release");

    // Exhaustive sweep.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), "sweep");
    end

    // Enable gating.
    step(1'b0, 3'b110, "en_low");
    step(1'b1, 3'b110, "en_high");
    step(1'b1, 3'b010, "code010");

    // Asynchronous reset between edges while out=80.
    step(1'b1, 3'b111, "pre_rst");
    #2 sys_rst_n = 1'b0;
    #1 check_reset("rst_mid");
    @(negedge sys_clk);
    check_reset("rst_mid_hold");
    sys_rst_n = 1'b1;
    prev_exp  = 8'h00;
    step(1'b1, 3'b011, "post_rst");
    step(1'b1, 3'b011, "repeat");

    // Randomized regression.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom), 3'($urandom_range(7, 0)), "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
